// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and constants for the control sequencer.
//               - ctrl_word_t : packed control word driven to the datapath
//               - CTRL_DEFAULT: control word produced before any decode override
//               - instrType and opcode constants
//               - ctrl_state_t: sequencer state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef struct packed {
    logic       we_reg;
    logic       pcControl;
    logic       memory_en;
    logic       aluBsel;
    logic       aluAsel;
    logic       jump;
    logic       branch;
    logic       muldiv;
    logic       illegal;
    logic [1:0] wdSelect;    // 00 ALU, 01 memory, 10 PC+4, 11 imm
    logic [1:0] store_size;  // 00 byte, 01 half, 10 word, 11 no store
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_DEFAULT = '{
    we_reg:     1'b0,
    pcControl:  1'b0,
    memory_en:  1'b0,
    aluBsel:    1'b0,
    aluAsel:    1'b1,
    jump:       1'b0,
    branch:     1'b0,
    muldiv:     1'b0,
    illegal:    1'b0,
    wdSelect:   2'b00,
    store_size: 2'b11
  };

  // instrType encodings
  localparam logic [2:0] c_IT_U = 3'b001;
  localparam logic [2:0] c_IT_J = 3'b010;
  localparam logic [2:0] c_IT_B = 3'b011;
  localparam logic [2:0] c_IT_I = 3'b100;
  localparam logic [2:0] c_IT_S = 3'b101;
  localparam logic [2:0] c_IT_R = 3'b110;

  // Opcodes the decoder distinguishes
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_MD_WAIT  = 2'd3
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Purely combinational decode of instruction fields into a
//               ctrl_word_t.
// Ports       : i_instr_type [2:0] - instruction format class
//               i_op         [6:0] - opcode
//               i_funct3     [2:0] - funct3 field
//               i_funct7_0         - instruction bit 25
//               o_word             - decoded control word
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int EN_MULDIV = 1
) (
  input  logic [2:0] i_instr_type,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_0,
  output ctrl_word_t o_word
);

  ctrl_word_t w_word;

  always_comb begin
    w_word = CTRL_DEFAULT;
    case (i_instr_type)
      c_IT_U: begin
        w_word.we_reg = 1'b1;
        if (i_op == c_OPC_AUIPC) begin
          w_word.aluAsel  = 1'b0;
          w_word.wdSelect = 2'b00;
        end else begin
          w_word.wdSelect = 2'b11;
        end
      end
      c_IT_J: begin
        w_word.we_reg    = 1'b1;
        w_word.pcControl = 1'b1;
        w_word.jump      = 1'b1;
        w_word.wdSelect  = 2'b10;
        w_word.aluAsel   = 1'b0;
      end
      c_IT_B: begin
        w_word.branch    = 1'b1;
        w_word.pcControl = 1'b1;
        w_word.wdSelect  = 2'b10;
        w_word.aluAsel   = 1'b0;
      end
      c_IT_I: begin
        case (i_op)
          c_OPC_JALR: begin
            w_word.we_reg    = 1'b1;
            w_word.pcControl = 1'b1;
            w_word.jump      = 1'b1;
            w_word.wdSelect  = 2'b10;
          end
          c_OPC_LOAD: begin
            w_word.we_reg    = 1'b1;
            w_word.memory_en = 1'b1;
            w_word.wdSelect  = 2'b01;
          end
          c_OPC_OPIMM: begin
            w_word.we_reg = 1'b1;
          end
          default: begin
            w_word.illegal = 1'b1;
          end
        endcase
      end
      c_IT_S: begin
        w_word.memory_en = 1'b1;
        case (i_funct3)
          3'b000:  w_word.store_size = 2'b00;
          3'b001:  w_word.store_size = 2'b01;
          3'b010:  w_word.store_size = 2'b10;
          default: begin
            w_word.store_size = 2'b11;
            w_word.illegal    = 1'b1;
          end
        endcase
      end
      c_IT_R: begin
        w_word.aluBsel = 1'b1;
        // SYSTEM and FENCE share the R slot but never write a register
        w_word.we_reg  = !((i_op == c_OPC_SYSTEM) || (i_op == c_OPC_FENCE));
        w_word.muldiv  = (EN_MULDIV != 0) && (i_op == c_OPC_OP) && i_funct7_0;
      end
      default: begin
        w_word.illegal = 1'b1;
      end
    endcase
  end

  assign o_word = w_word;

endmodule
`default_nettype wire

// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
// Module      : control_seq
// Description : Registered, handshaked control stage. Decodes instruction
//               fields into a held control word and sequences multi-cycle
//               loads/stores (wait for mem_done) and MUL/DIV (fixed latency).
// Ports       : CLK, RESET (async, active-high)
//               in_valid/in_ready    - upstream handshake (in_ready is comb)
//               op, instrType, funct3, funct7_0 - decode fields
//               flush                - drop held / in-flight work
//               out_valid/out_ready  - downstream handshake
//               we_reg..store_size   - registered control word
//               mem_done             - memory completion (MEM_WAIT only)
//               busy                 - high in MEM_WAIT or MD_WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module control_seq
  import ctrl_pkg::*;
#(
  parameter int EN_MULDIV     = 1,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] op,
  input  logic [2:0] instrType,
  input  logic [2:0] funct3,
  input  logic       funct7_0,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       we_reg,
  output logic       pcControl,
  output logic       memory_en,
  output logic       aluBsel,
  output logic       aluAsel,
  output logic       jump,
  output logic       branch,
  output logic       muldiv,
  output logic       illegal,
  output logic [1:0] wdSelect,
  output logic [1:0] store_size,
  input  logic       mem_done,
  output logic       busy
);

  localparam int                 c_CNT_W   = $clog2(MULDIV_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_MD_LOAD = c_CNT_W'(MULDIV_CYCLES - 1);

  ctrl_state_t        r_state;
  ctrl_word_t         r_word;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_out_valid;
  logic               r_busy;

  ctrl_word_t         w_dec;
  logic               w_accept;

  ctrl_decode #(
    .EN_MULDIV (EN_MULDIV)
  ) u_decode (
    .i_instr_type (instrType),
    .i_op         (op),
    .i_funct3     (funct3),
    .i_funct7_0   (funct7_0),
    .o_word       (w_dec)
  );

  // In HOLD a new word may only replace the held one when the held word
  // retires this cycle and does not itself need a wait state.
  always_comb begin
    in_ready = 1'b0;
    if (!RESET && !flush) begin
      case (r_state)
        S_IDLE:  in_ready = 1'b1;
        S_HOLD:  in_ready = out_ready & !r_word.memory_en & !r_word.muldiv;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_word      <= CTRL_DEFAULT;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush && (r_state != S_MEM_WAIT)) begin
      // A committed memory access cannot be recalled, so MEM_WAIT ignores flush
      r_state     <= S_IDLE;
      r_word      <= CTRL_DEFAULT;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_word      <= w_dec;
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            if (r_word.memory_en) begin
              r_state     <= S_MEM_WAIT;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
            end else if (r_word.muldiv) begin
              r_state     <= S_MD_WAIT;
              r_cnt       <= c_MD_LOAD;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
            end else if (w_accept) begin
              r_word      <= w_dec;
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_MD_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign we_reg     = r_word.we_reg;
  assign pcControl  = r_word.pcControl;
  assign memory_en  = r_word.memory_en;
  assign aluBsel    = r_word.aluBsel;
  assign aluAsel    = r_word.aluAsel;
  assign jump       = r_word.jump;
  assign branch     = r_word.branch;
  assign muldiv     = r_word.muldiv;
  assign illegal    = r_word.illegal;
  assign wdSelect   = r_word.wdSelect;
  assign store_size = r_word.store_size;

endmodule
`default_nettype wire

// File: tb/tb_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_seq
// Description : Directed self-checking bench for control_seq. Instance dut_a
//               has MUL/DIV enabled, dut_b has it disabled; both share stimulus.
//               Control words are compared as the packed 13-bit concatenation
//               {we_reg,pcControl,memory_en,aluBsel,aluAsel,jump,branch,
//                muldiv,illegal,wdSelect,store_size}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_seq;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       in_valid;
  logic [6:0] op;
  logic [2:0] instrType;
  logic [2:0] funct3;
  logic       funct7_0;
  logic       flush;
  logic       out_ready;
  logic       mem_done;

  logic       rdy_a, ov_a, busy_a;
  logic       we_a, pc_a, me_a, bs_a, as_a, j_a, br_a, md_a, il_a;
  logic [1:0] wd_a, ss_a;
  logic       rdy_b, ov_b, busy_b;
  logic       we_b, pc_b, me_b, bs_b, as_b, j_b, br_b, md_b, il_b;
  logic [1:0] wd_b, ss_b;

  logic [12:0] word_a, word_b;
  assign word_a = {we_a, pc_a, me_a, bs_a, as_a, j_a, br_a, md_a, il_a, wd_a, ss_a};
  assign word_b = {we_b, pc_b, me_b, bs_b, as_b, j_b, br_b, md_b, il_b, wd_b, ss_b};

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  control_seq #(.EN_MULDIV(1), .MULDIV_CYCLES(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(rdy_a),
    .op(op), .instrType(instrType), .funct3(funct3), .funct7_0(funct7_0),
    .flush(flush), .out_valid(ov_a), .out_ready(out_ready),
    .we_reg(we_a), .pcControl(pc_a), .memory_en(me_a), .aluBsel(bs_a),
    .aluAsel(as_a), .jump(j_a), .branch(br_a), .muldiv(md_a), .illegal(il_a),
    .wdSelect(wd_a), .store_size(ss_a), .mem_done(mem_done), .busy(busy_a)
  );

  control_seq #(.EN_MULDIV(0), .MULDIV_CYCLES(4)) dut_b (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(rdy_b),
    .op(op), .instrType(instrType), .funct3(funct3), .funct7_0(funct7_0),
    .flush(flush), .out_valid(ov_b), .out_ready(out_ready),
    .we_reg(we_b), .pcControl(pc_b), .memory_en(me_b), .aluBsel(bs_b),
    .aluAsel(as_b), .jump(j_b), .branch(br_b), .muldiv(md_b), .illegal(il_b),
    .wdSelect(wd_b), .store_size(ss_b), .mem_done(mem_done), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] it, input logic [6:0] o,
                           input logic [2:0] f3, input logic f7);
    instrType = it;
    op        = o;
    funct3    = f3;
    funct7_0  = f7;
  endtask

  initial begin
    RESET     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    mem_done  = 1'b0;
    set_instr(3'b000, 7'd0, 3'd0, 1'b0);

    // ---------------- reset ----------------
    #2;
    check_eq("rst_in_ready", 16'(rdy_a), 16'h0);
    @(negedge CLK);
    check_eq("rst_out_valid", 16'(ov_a), 16'h0);
    check_eq("rst_word", 16'(word_a), 16'h0103);
    check_eq("rst_busy", 16'(busy_a), 16'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_eq("rel_in_ready", 16'(rdy_a), 16'h1);
    next_cycle();

    // ---------------- back-to-back OP-IMM, AUIPC, JAL ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_instr(3'b100, 7'b0010011, 3'd0, 1'b0);
    @(negedge CLK);
    check_eq("b2b_rdy_idle", 16'(rdy_a), 16'h1);
    next_cycle();
    set_instr(3'b001, 7'b0010111, 3'd0, 1'b0);
    @(negedge CLK);
    check_eq("b2b_opimm_ov", 16'(ov_a), 16'h1);
    check_eq("b2b_opimm_word", 16'(word_a), 16'h1103);
    check_eq("b2b_rdy_hold", 16'(rdy_a), 16'h1);
    next_cycle();
    set_instr(3'b010, 7'b1101111, 3'd0, 1'b0);
    @(negedge CLK);
    check_eq("b2b_auipc_ov", 16'(ov_a), 16'h1);
    check_eq("b2b_auipc_word", 16'(word_a), 16'h1003);
    next_cycle();
    in_valid = 1'b0;
    @(negedge CLK);
    check_eq("b2b_jal_ov", 16'(ov_a), 16'h1);
    check_eq("b2b_jal_word", 16'(word_a), 16'h188B);
    next_cycle();
    @(negedge CLK);
    check_eq("b2b_drain_ov", 16'(ov_a), 16'h0);
    next_cycle();

    // ---------------- SW with mem_done 3 cycles after handoff ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_instr(3'b101, 7'b0100011, 3'b010, 1'b0);
    @(negedge CLK);
    check_eq("sw_rdy_idle", 16'(rdy_a), 16'h1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge CLK);
    check_eq("sw_ov", 16'(ov_a), 16'h1);
    check_eq("sw_word", 16'(word_a), 16'h0502);
    check_eq("sw_rdy_stall", 16'(rdy_a), 16'h0);
    next_cycle();
    @(negedge CLK);
    check_eq("sw_word_held", 16'(word_a), 16'h0502);
    next_cycle();
    out_ready = 1'b1;
    mem_done  = 1'b1;  // must be ignored: block is still in HOLD
    @(negedge CLK);
    check_eq("sw_rdy_handoff", 16'(rdy_a), 16'h0);
    check_eq("sw_busy_handoff", 16'(busy_a), 16'h0);
    next_cycle();
    for (int k = 1; k <= 3; k++) begin
      mem_done = (k == 3);
      @(negedge CLK);
      check_eq($sformatf("sw_busy_%0d", k), 16'(busy_a), 16'h1);
      check_eq($sformatf("sw_rdy_wait_%0d", k), 16'(rdy_a), 16'h0);
      check_eq($sformatf("sw_ov_wait_%0d", k), 16'(ov_a), 16'h0);
      next_cycle();
    end
    mem_done = 1'b0;
    @(negedge CLK);
    check_eq("sw_busy_done", 16'(busy_a), 16'h0);
    check_eq("sw_rdy_done", 16'(rdy_a), 16'h1);
    next_cycle();

    // ---------------- MUL, enabled vs disabled ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_instr(3'b110, 7'b0110011, 3'b000, 1'b1);
    @(negedge CLK);
    check_eq("mul_rdy_idle", 16'(rdy_a), 16'h1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge CLK);
    check_eq("mul_ov", 16'(ov_a), 16'h1);
    check_eq("mul_word_en", 16'(word_a), 16'h1323);
    check_eq("mul_rdy_en", 16'(rdy_a), 16'h0);
    check_eq("mul_word_dis", 16'(word_b), 16'h1303);
    check_eq("mul_rdy_dis", 16'(rdy_b), 16'h1);
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check_eq($sformatf("mul_busy_%0d", k), 16'(busy_a), 16'h1);
      check_eq($sformatf("mul_rdy_wait_%0d", k), 16'(rdy_a), 16'h0);
      check_eq($sformatf("mul_busy_dis_%0d", k), 16'(busy_b), 16'h0);
      next_cycle();
    end
    @(negedge CLK);
    check_eq("mul_busy_done", 16'(busy_a), 16'h0);
    check_eq("mul_rdy_done", 16'(rdy_a), 16'h1);
    next_cycle();

    // ---------------- flush in HOLD with out_ready=0 ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_instr(3'b100, 7'b0010011, 3'd0, 1'b0);
    @(negedge CLK);
    next_cycle();
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge CLK);
    check_eq("fl_hold_ov", 16'(ov_a), 16'h1);
    check_eq("fl_hold_rdy", 16'(rdy_a), 16'h0);
    next_cycle();
    flush = 1'b0;
    @(negedge CLK);
    check_eq("fl_hold_ov_after", 16'(ov_a), 16'h0);
    check_eq("fl_hold_rdy_after", 16'(rdy_a), 16'h1);

    // flush in IDLE blocks an offered instruction
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    check_eq("fl_idle_rdy", 16'(rdy_a), 16'h0);
    next_cycle();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge CLK);
    check_eq("fl_idle_ov", 16'(ov_a), 16'h0);
    next_cycle();

    // ---------------- flush in MEM_WAIT (load) ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_instr(3'b100, 7'b0000011, 3'b010, 1'b0);
    @(negedge CLK);
    next_cycle();
    in_valid = 1'b0;
    @(negedge CLK);
    check_eq("ld_word", 16'(word_a), 16'h1507);
    out_ready = 1'b1;
    next_cycle();
    flush = 1'b1;
    @(negedge CLK);
    check_eq("fl_mem_busy", 16'(busy_a), 16'h1);
    next_cycle();
    flush = 1'b0;
    @(negedge CLK);
    check_eq("fl_mem_busy_kept", 16'(busy_a), 16'h1);
    check_eq("fl_mem_rdy", 16'(rdy_a), 16'h0);
    next_cycle();
    mem_done = 1'b1;
    @(negedge CLK);
    check_eq("fl_mem_busy_done", 16'(busy_a), 16'h1);
    next_cycle();
    mem_done = 1'b0;
    @(negedge CLK);
    check_eq("fl_mem_idle_busy", 16'(busy_a), 16'h0);
    check_eq("fl_mem_idle_rdy", 16'(rdy_a), 16'h1);
    next_cycle();

    // ---------------- flush in MD_WAIT ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_instr(3'b110, 7'b0110011, 3'b000, 1'b1);
    @(negedge CLK);
    next_cycle();
    in_valid = 1'b0;
    @(negedge CLK);
    next_cycle();
    flush = 1'b1;
    @(negedge CLK);
    check_eq("fl_md_busy", 16'(busy_a), 16'h1);
    next_cycle();
    flush = 1'b0;
    @(negedge CLK);
    check_eq("fl_md_busy_after", 16'(busy_a), 16'h0);
    check_eq("fl_md_rdy_after", 16'(rdy_a), 16'h1);
    next_cycle();

    // ---------------- illegal encodings ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_instr(3'b111, 7'd0, 3'd0, 1'b0);
    @(negedge CLK);
    next_cycle();
    set_instr(3'b101, 7'b0100011, 3'b011, 1'b0);
    @(negedge CLK);
    check_eq("ill_type_ov", 16'(ov_a), 16'h1);
    check_eq("ill_type_word", 16'(word_a), 16'h0113);
    out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    @(negedge CLK);
    check_eq("ill_s_ov", 16'(ov_a), 16'h1);
    check_eq("ill_s_word", 16'(word_a), 16'h0513);
    next_cycle();
    mem_done = 1'b1;
    next_cycle();
    mem_done = 1'b0;
    @(negedge CLK);
    check_eq("ill_s_busy_done", 16'(busy_a), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_seq.md
# control_seq

Registered, handshaked control stage for the multi-cycle core. It decodes `instrType`/`op`/`funct3` into the control word the datapath uses and holds that word in an output register. It also sequences instructions that cannot retire in one cycle: loads and stores wait for `mem_done`, and optional MUL/DIV waits a fixed latency. It sits between fetch/decode and the register-file/ALU/memory datapath, and adds the stall, flush and illegal-instruction behaviour that the single-cycle control path lacks.

## Interface
- `EN_MULDIV`, default 1: when 1, R-type `op=0110011` with `funct7_0=1` is flagged `muldiv` and sequenced; when 0, `muldiv` is forced to 0.
- `MULDIV_CYCLES`, default 4, legal range ≥1: cycles spent in MD_WAIT.
- `CLK` in 1: single clock; all state on rising edge.
- `RESET` in 1: asynchronous, active-high.
- `in_valid` in 1: decode fields valid.
- `in_ready` out 1: stage can accept.
- `op` in 7: opcode.
- `instrType` in 3: 001 U, 010 J, 011 B, 100 I, 101 S, 110 R.
- `funct3` in 3: funct3 field.
- `funct7_0` in 1: instruction bit 25.
- `flush` in 1: discard held/in-flight work.
- `out_valid` out 1: registered control word valid.
- `out_ready` in 1: datapath consumes word.
- `we_reg`, `pcControl`, `memory_en`, `aluBsel`, `aluAsel`, `jump`, `branch`, `muldiv`, `illegal` out 1 each: registered control bits.
- `wdSelect` out 2: 00 ALU, 01 memory, 10 PC+4, 11 imm.
- `store_size` out 2: 00 byte, 01 half, 10 word, 11 no store.
- `mem_done` in 1: memory access complete (sampled only in MEM_WAIT).
- `busy` out 1: high in MEM_WAIT or MD_WAIT.

## Operation
- Decode defaults: all bits 0, except `aluAsel=1`, `wdSelect=00`, `store_size=11`.
- U: `we_reg=1`. AUIPC (`op=0010111`) sets `aluAsel=0`, `wdSelect=00`; otherwise `wdSelect=11`.
- J: sets `we_reg`, `pcControl`, `jump`; `wdSelect=10`; `aluAsel=0`.
- B: sets `branch`, `pcControl`; `wdSelect=10`; `aluAsel=0`.
- I: the three cases are:
  - JALR (`1100111`): sets `we_reg`, `pcControl`, `jump`; `wdSelect=10`.
  - Load (`0000011`): sets `we_reg`, `memory_en`; `wdSelect=01`.
  - OP-IMM (`0010011`): sets `we_reg`.
  - Any other opcode sets `illegal`.
- S: sets `memory_en`. `funct3` 000/001/010 map to `store_size` 00/01/10; any other value gives `store_size=11` and sets `illegal`.
- R: `aluBsel=1`. `we_reg=1` unless `op` is `1110011` or `0001111`. `muldiv` is set per `EN_MULDIV`.
- Other `instrType`: defaults, with `illegal=1`. An illegal word still passes through the handshake; trap handling is downstream.
- States: IDLE, HOLD, MEM_WAIT, MD_WAIT.
- IDLE: `in_ready=1`. Accepting an instruction (`in_valid & in_ready`) loads the word and moves to HOLD.
- HOLD: `out_valid=1`. On `out_ready` the next state is:
  - `memory_en` → MEM_WAIT.
  - `muldiv` → MD_WAIT, with counter loaded to `MULDIV_CYCLES-1`.
  - Otherwise, if a new instruction is accepted in the same cycle → stay in HOLD with the new word.
  - Otherwise → IDLE.
- `in_ready` in HOLD = `out_ready & !memory_en & !muldiv` of the held word.
- MEM_WAIT: `out_valid=0`, `in_ready=0`. Moves to IDLE on `mem_done`.
- MD_WAIT: `out_valid=0`, `in_ready=0`. Counter decrements each cycle; moves to IDLE in the cycle it reads 0.
- `flush` overrides every input handshake (`in_ready` forced 0), with per-state behaviour:
  - IDLE or HOLD → IDLE, word dropped.
  - MD_WAIT → IDLE, counter cleared.
  - MEM_WAIT: ignored, because the memory access is already committed.

## Timing
- Reset values: state IDLE, `out_valid=0`, control outputs at decode defaults (`illegal=0`), counter 0, `busy=0`.
- `in_ready` is 0 while `RESET` is asserted.
- Latency: accepted in cycle N → `out_valid` in N+1.
- Non-memory, non-muldiv words sustain 1/cycle when `out_ready` is held high.
- Memory op handed off in cycle N, `mem_done` in cycle M>N → `in_ready=1` in M+1.
- `mem_done` in cycle N itself is ignored.
- MUL/DIV handed off in cycle N → `in_ready=1` in N+1+`MULDIV_CYCLES`.
- Control outputs are held stable while `out_valid & !out_ready`.
- `in_ready` is the only combinational output: it depends on state, the held word, `out_ready`, `flush` and `RESET`.
- Counter width is `$clog2(MULDIV_CYCLES+1)`.
- `RESET` mid-operation returns the block to IDLE immediately (asynchronous), including in MEM_WAIT.

## Structure
- Package `ctrl_pkg` holds:
  - `ctrl_word_t` packed struct of all control outputs.
  - `CTRL_DEFAULT` constant.
  - instrType constants.
  - Opcode constants (AUIPC, JALR, LOAD, OPIMM, OP, SYSTEM, FENCE).
  - `ctrl_state_t` enum.
- Sub-module `ctrl_decode`: purely combinational decode table, fields → `ctrl_word_t`, parameterised by `EN_MULDIV`.
- `control_seq` owns the FSM, the output register and the counter.

## Test plan
- Reset → `out_valid=0`, `store_size=11`, `aluAsel=1`, `busy=0`; after release `in_ready=1`.
- Back-to-back OP-IMM, AUIPC, JAL with `out_ready=1`:
  - One word per cycle.
  - AUIPC gives `aluAsel=0`, `wdSelect=00`; JAL gives `jump=1`, `wdSelect=10`.
- SW (`instrType=101`, `funct3=010`) with `mem_done` 3 cycles after handoff:
  - `store_size=10`, `memory_en=1`.
  - `busy=1` for 3 cycles; `in_ready` returns the cycle after `mem_done`.
- MUL (`op=0110011`, `funct7_0=1`) with `MULDIV_CYCLES=4` → `muldiv=1`; `busy` high 4 cycles. The same stimulus with `EN_MULDIV=0` gives `muldiv=0` and no stall.
- `flush` during HOLD with `out_ready=0` → `out_valid=0` next cycle. `flush` during MEM_WAIT → remains in MEM_WAIT until `mem_done`.
- Illegal cases:
  - `instrType=111` → `illegal=1`, defaults elsewhere.
  - S-type `funct3=011` → `illegal=1`, `store_size=11`.
